// File: rtl/doitgen_pkg.sv
// Shared dimensions and loader state encoding for the doitgen operand path.
// Default tensor sizes plus widths derived from them.
package doitgen_pkg;

  localparam int DOIT_DW = 8;
  localparam int DOIT_NR = 2;
  localparam int DOIT_NQ = 2;
  localparam int DOIT_NP = 2;

  localparam int NA  = DOIT_NR * DOIT_NQ * DOIT_NP;
  localparam int NX  = DOIT_NP * DOIT_NP;
  localparam int A_W = NA * DOIT_DW;
  localparam int X_W = NX * DOIT_DW;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_X,
    PRESENT,
    DRAIN
  } ld_state_e;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/doitgen_operand_loader.sv
// Byte-serial loader that packs one A tensor and one X matrix frame,
// dropping frames whose in_last marker is misplaced.
module doitgen_operand_loader
  import doitgen_pkg::*;
#(
  parameter int DW = DOIT_DW,
  parameter int NR = DOIT_NR,
  parameter int NQ = DOIT_NQ,
  parameter int NP = DOIT_NP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NR*NQ*NP*DW-1:0] out_a,
  output logic [NP*NP*DW-1:0]   out_x,
  output logic                  err_frame
);

  localparam int EA = NR * NQ * NP;
  localparam int EX = NP * NP;
  localparam int AW = EA * DW;
  localparam int XW = EX * DW;
  localparam int CW = cnt_w(EA, EX);

  ld_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [AW-1:0]   a_q;
  logic [XW-1:0]   x_q;
  logic            acc;

  assign acc = in_valid && in_ready;

  // state, element counter and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // frame sequencing: count elements, check the in_last position
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (acc) begin
          if (in_last) begin
            err_d   = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == CW'(EA - 1)) begin
            state_d = LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (acc) begin
          cnt_d = '0;
          if (cnt_q == CW'(EX - 1)) begin
            if (in_last) begin
              state_d = PRESENT;
            end else begin
              state_d = DRAIN;
              err_d   = 1'b1;
            end
          end else if (in_last) begin
            state_d = LOAD_A;
            err_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (acc && in_last) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // handshake outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      LOAD_A, LOAD_X, DRAIN: in_ready = !rst;
      PRESENT:               out_valid = 1'b1;
      default:               in_ready = 1'b0;
    endcase
  end

  // write each accepted byte straight into its MSB-first slot
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      x_q <= '0;
    end else if (acc) begin
      for (int i = 0; i < EA; i++) begin
        if (state_q == LOAD_A && cnt_q == CW'(i))
          a_q[AW-1-i*DW -: DW] <= in_data;
      end
      for (int j = 0; j < EX; j++) begin
        if (state_q == LOAD_X && cnt_q == CW'(j))
          x_q[XW-1-j*DW -: DW] <= in_data;
      end
    end
  end

  assign out_a     = a_q;
  assign out_x     = x_q;
  assign err_frame = err_q;

endmodule

// File: tb/tb_doitgen_operand_loader.sv
// Directed bench for doitgen_operand_loader with a frame-level
// reference model checked every cycle on the falling edge.
module tb_doitgen_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_a;
  logic [31:0] out_x;
  logic        err_frame;

  int total = 0;
  int bad = 0;

  doitgen_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_x     (out_x),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // frame-level model: collect bytes, present a frame of exactly 12
  // bytes whose last byte carries in_last, otherwise flag an error
  logic [7:0]  q[$];
  bit          m_drain = 0;
  bit          m_pres = 0;
  bit          m_err = 0;
  logic [63:0] m_a = '0;
  logic [31:0] m_x = '0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_drain = 0;
      m_pres  = 0;
      m_err   = 0;
    end else begin
      m_err = 0;
      if (m_pres) begin
        if (out_ready) m_pres = 0;
      end else if (in_valid) begin
        if (m_drain) begin
          if (in_last) m_drain = 0;
        end else begin
          q.push_back(in_data);
          if (q.size() == 12) begin
            if (in_last) begin
              m_pres = 1;
              m_a = '0;
              m_x = '0;
              for (int i = 0; i < 8; i++) m_a = {m_a[55:0], q[i]};
              for (int i = 8; i < 12; i++) m_x = {m_x[23:0], q[i]};
            end else begin
              m_err   = 1;
              m_drain = 1;
            end
            q.delete();
          end else if (in_last) begin
            m_err = 1;
            q.delete();
          end
        end
      end
    end
  end

  int          vcnt = 0;
  int          ecnt = 0;
  logic [63:0] last_a = '0;
  logic [31:0] last_x = '0;

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_pres));
    chk("in_ready", 64'(in_ready), 64'(!rst && !m_pres));
    chk("err_frame", 64'(err_frame), 64'(m_err));
    if (m_pres) begin
      chk("out_a", out_a, m_a);
      chk("out_x", 64'(out_x), 64'(m_x));
    end
    if (out_valid) begin
      vcnt++;
      last_a = out_a;
      last_x = out_x;
    end
    if (err_frame) ecnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input int gap);
    int n;
    repeat (gap) tick();
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got in_ready=0 want 1");
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base, input int n,
                       input int lastpos, input int maxgap);
    for (int i = 0; i < n; i++)
      send(base + 8'(i), (i == lastpos), $urandom_range(0, maxgap));
  endtask

  int v0, e0;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_a", out_a, 64'h0);
    chk("rst_out_x", 64'(out_x), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_valid", 64'(out_valid), 64'h0);

    // nominal
    out_ready = 1'b1;
    v0 = vcnt;
    frame(8'h01, 12, 11, 0);
    chk("nom_valid_now", 64'(out_valid), 64'h1);
    tick();
    chk("nom_valid_fall", 64'(out_valid), 64'h0);
    chk("nom_ready_back", 64'(in_ready), 64'h1);
    chk("nom_a", last_a, 64'h0102030405060708);
    chk("nom_x", 64'(last_x), 64'h090A0B0C);
    chk("nom_vcycles", 64'(vcnt - v0), 64'd1);

    // backpressure
    out_ready = 1'b0;
    frame(8'h01, 12, 11, 0);
    v0 = vcnt;
    repeat (5) tick();
    chk("bp_hold_valid", 64'(out_valid), 64'h1);
    chk("bp_hold_a", out_a, 64'h0102030405060708);
    out_ready = 1'b1;
    tick();
    chk("bp_vcycles", 64'(vcnt - v0), 64'd6);
    frame(8'h11, 12, 11, 0);
    tick();
    chk("bp2_a", last_a, 64'h1112131415161718);
    chk("bp2_x", 64'(last_x), 64'h191A1B1C);

    // early last on the 7th byte
    v0 = vcnt;
    e0 = ecnt;
    frame(8'h21, 7, 6, 0);
    repeat (3) tick();
    chk("early_err", 64'(ecnt - e0), 64'd1);
    chk("early_novalid", 64'(vcnt - v0), 64'd0);
    frame(8'h31, 12, 11, 0);
    tick();
    chk("early_next_a", last_a, 64'h3132333435363738);
    chk("early_next_x", 64'(last_x), 64'h393A3B3C);

    // missing last, then drain
    v0 = vcnt;
    e0 = ecnt;
    frame(8'h41, 12, -1, 0);
    tick();
    chk("miss_err", 64'(ecnt - e0), 64'd1);
    frame(8'hF0, 3, 2, 0);
    repeat (2) tick();
    chk("miss_novalid", 64'(vcnt - v0), 64'd0);
    chk("miss_err_once", 64'(ecnt - e0), 64'd1);
    frame(8'h51, 12, 11, 0);
    tick();
    chk("miss_next_a", last_a, 64'h5152535455565758);

    // reset mid-frame
    v0 = vcnt;
    frame(8'hE0, 5, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frame(8'hA0, 12, 11, 0);
    tick();
    chk("rst_mid_vcnt", 64'(vcnt - v0), 64'd1);
    chk("rst_mid_a", last_a, 64'hA0A1A2A3A4A5A6A7);
    chk("rst_mid_x", 64'(last_x), 64'hA8A9AAAB);

    // input gaps
    v0 = vcnt;
    frame(8'h60, 12, 11, 3);
    frame(8'h70, 12, 11, 3);
    frame(8'h80, 12, 11, 3);
    repeat (2) tick();
    chk("gap_vcnt", 64'(vcnt - v0), 64'd3);
    chk("gap_a", last_a, 64'h8081828384858687);
    chk("gap_x", 64'(last_x), 64'h88898A8B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/doitgen_operand_loader.md
# doitgen_operand_loader

Upstream feeder for the `doitgen` tensor-contraction stage. It accepts a byte-serial operand stream through a valid/ready handshake and assembles one frame of the 3-D A tensor followed by the 2-D X matrix. It presents both as packed, MSB-first words, in exactly the element order the kernel unpacks. It detects and drops malformed frames so the kernel never sees a partially loaded operand set.

## Interface
Parameters:
- `DW`, 8, element width in bits.
- `NR`, 2, A tensor r-dimension.
- `NQ`, 2, A tensor q-dimension.
- `NP`, 2, A tensor s/p-dimension; X is NP×NP.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  DW  element value.
- `in_last`  in  1  marks the final element of a frame.
- `out_valid`  out  1  complete frame held on `out_a`/`out_x`.
- `out_ready`  in  1  consumer takes the frame.
- `out_a`  out  NR·NQ·NP·DW  packed A tensor.
- `out_x`  out  NP·NP·DW  packed X matrix.
- `err_frame`  out  1  one-cycle pulse on a malformed frame.

## Operation
- Frame length: NA = NR·NQ·NP elements of A, then NX = NP·NP elements of X. The default frame is 8 + 4 = 12 bytes.
- A order is row-major over (r, q, s). The first accepted A element lands in the top DW bits of `out_a`. X order is row-major over (s, p), with the first X element in the top bits of `out_x`.
- A byte is accepted on a cycle with `in_valid && in_ready`. It is written directly into its slot in the output register. Accepted bytes do not cause any other output change.
- States:
  - `LOAD_A`: count accepted bytes 0..NA-1. After byte NA-1 is accepted, go to `LOAD_X`.
  - `LOAD_X`: count 0..NX-1. When byte NX-1 is accepted with `in_last`=1, go to `PRESENT`.
  - `PRESENT`: `out_valid`=1 and `in_ready`=0. On `out_ready`=1, go to `LOAD_A` with counters cleared.
  - `DRAIN`: accept and discard bytes. The byte accepted with `in_last`=1 returns the block to `LOAD_A`.
- Early last: `in_last`=1 on any byte before the final X byte, whether in `LOAD_A` or `LOAD_X`. Then `err_frame` pulses, counters clear, and the block goes to `LOAD_A`. The partial frame is never presented.
- Missing last: the final X byte is accepted with `in_last`=0. Then `err_frame` pulses and the block goes to `DRAIN`.
- `in_ready` is 1 in `LOAD_A`, `LOAD_X` and `DRAIN`, and 0 in `PRESENT` and while `rst` is high.
- `out_a`/`out_x` are only meaningful while `out_valid`=1. They must hold stable for the whole `PRESENT` state.
- All counters are sized to clog2(max(NA,NX)). The counter wraps to 0 on every state change.

## Timing
- Reset values:
  - state `LOAD_A`, counters 0.
  - `out_valid`=0, `err_frame`=0.
  - `out_a`=0, `out_x`=0.
  - `in_ready` is 0 during reset and 1 on the first cycle after `rst` is released.
- Latency: `out_valid` rises on the cycle after the final X byte is accepted.
- Handoff: when `out_valid && out_ready`, `out_valid` falls and `in_ready` rises on the next cycle. There are no dead cycles beyond this one.
- `err_frame` is asserted for exactly one cycle, on the cycle after the offending byte.
- `in_valid` gaps of any length are legal and only stall the counters.
- `rst` mid-frame or mid-`PRESENT` discards all state. There is no `out_valid` until a full new frame has been loaded.
- `out_ready` is ignored outside `PRESENT`.

## Structure
- Shared package `doitgen_pkg` holds:
  - default `DW`/`NR`/`NQ`/`NP` constants;
  - derived `NA`, `NX`, `A_W`, `X_W` localparams;
  - the loader state enum (`LOAD_A`, `LOAD_X`, `PRESENT`, `DRAIN`).
- `doitgen` imports the same dimension constants.
- No sub-module is needed. The single element counter and slot decode are inline.

## Test plan
- Nominal frame: bytes 0x01–0x0C with `in_last` on 0x0C and `out_ready`=1. Required: `out_a`=64'h0102030405060708 and `out_x`=32'h090A0B0C. `out_valid` is high for 1 cycle, one cycle after the last byte. `in_ready` is back to 1 on the next cycle.
- Backpressure: same frame with `out_ready` held low for 5 cycles. Required: `out_valid` and both words stable for 5 cycles and `in_ready`=0 throughout. After `out_ready`=1, a second frame 0x11–0x1C yields `out_a`=64'h1112131415161718.
- Early last: `in_last` on the 7th byte. Required: `err_frame` pulses once and `out_valid` stays 0. The next 12-byte frame is presented correctly.
- Missing last: 12 bytes with no `in_last`, then 3 bytes with `in_last` on the third. Required: `err_frame` pulses after byte 12 and there is no `out_valid`. A following good frame is presented.
- Reset mid-frame: `rst` for 1 cycle after 5 bytes, then a full frame 0xA0–0xAB. Required: `out_a`=64'hA0A1A2A3A4A5A6A7 and `out_x`=32'hA8A9AAAB.
- Random `in_valid` gaps (0–3 idle cycles) across 3 frames. Required: every frame is packed identically to the gap-free case.
